// File: rtl/mips_pkg.sv
// Shared MIPS J-type encoding types and helpers.
// Holds the default J/JAL opcodes, the request/response payloads, and the
// pure function that turns a registered request into an encoded response.
package mips_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INDEX_W    = 26;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned REGION_LSB = 28;

  localparam logic [OP_W-1:0] OP_J_DEFAULT   = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL_DEFAULT = 6'b000011;

  typedef struct packed {
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] target;
    logic              link;
  } jfe_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  instr;
    logic [INDEX_W-1:0] index;
    logic               err_align;
    logic               err_region;
  } jfe_rsp_t;

  // Recover instr_index and build the full J/JAL word; flags are advisory only.
  function automatic jfe_rsp_t jfe_encode(input jfe_req_t req,
                                          input logic [OP_W-1:0] op_j,
                                          input logic [OP_W-1:0] op_jal);
    jfe_rsp_t rsp;
    rsp.index      = req.target[REGION_LSB-1:2];
    rsp.instr      = {(req.link ? op_jal : op_j), req.target[REGION_LSB-1:2]};
    rsp.err_align  = (req.target[1:0] != 2'b00);
    rsp.err_region = (req.target[ADDR_W-1:REGION_LSB] != req.pc_next[ADDR_W-1:REGION_LSB]);
    return rsp;
  endfunction

endpackage

// File: rtl/jfe_stage.sv
// Generic valid/ready pipeline register for any payload type T.
// Ports: clk, rst (sync, active-low); upstream in_valid/in_ready_c/in_data;
// downstream out_valid/out_ready/out_data. in_ready_c is combinational from
// state and out_ready only, never from in_valid.
module jfe_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready_c,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q, valid_d;
  T     data_q,  data_d;

  // Free to load when empty or when the current occupant leaves this cycle.
  assign in_ready_c = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_c) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/jump_field_encoder.sv
// Converts an absolute jump target back into a MIPS J-type instr_index and
// the full J/JAL word, flagging misaligned or out-of-region targets.
// Ports: clk, rst (sync, active-low); in_valid/in_ready with pc_next, target,
// link; out_valid/out_ready with index, instr, err_align, err_region;
// clr_cnt clears err_count, a saturating count of erroneous output handshakes.
module jump_field_encoder
  import mips_pkg::*;
#(
  parameter int unsigned     CNT_W  = 16,
  parameter logic [OP_W-1:0] OP_J   = OP_J_DEFAULT,
  parameter logic [OP_W-1:0] OP_JAL = OP_JAL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic [ADDR_W-1:0]  target,
  input  logic               link,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] index,
  output logic [ADDR_W-1:0]  instr,
  output logic               err_align,
  output logic               err_region,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   err_count
);

  jfe_req_t req_c;
  jfe_req_t s1_data;
  jfe_rsp_t rsp_c;
  jfe_rsp_t s2_data;
  logic     s1_valid;
  logic     s2_ready_c;

  assign req_c = '{pc_next: pc_next, target: target, link: link};

  // S1: capture the raw request.
  jfe_stage #(.T(jfe_req_t)) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready_c (in_ready),
    .in_data    (req_c),
    .out_valid  (s1_valid),
    .out_ready  (s2_ready_c),
    .out_data   (s1_data)
  );

  assign rsp_c = jfe_encode(s1_data, OP_J, OP_JAL);

  // S2: capture the encoded response; all outputs come straight from here.
  jfe_stage #(.T(jfe_rsp_t)) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s1_valid),
    .in_ready_c (s2_ready_c),
    .in_data    (rsp_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (s2_data)
  );

  assign index      = s2_data.index;
  assign instr      = s2_data.instr;
  assign err_align  = s2_data.err_align;
  assign err_region = s2_data.err_region;

  // Saturating error counter; clear beats a coincident increment.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && (s2_data.err_align || s2_data.err_region)
                 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_count = cnt_q;

endmodule

// File: tb/tb_jump_field_encoder.sv
// Self-checking bench for jump_field_encoder: table-driven vectors whose
// literal expectations are queued on input handshake and compared on output
// handshake, plus hand-written backpressure, reset, saturation and clear cases.
module tb_jump_field_encoder;

  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       pc_next;
  logic [31:0]       target;
  logic              link;
  logic              out_valid;
  logic              out_ready;
  logic [25:0]       index;
  logic [31:0]       instr;
  logic              err_align;
  logic              err_region;
  logic              clr_cnt;
  logic [CNT_W-1:0]  err_count;

  jump_field_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc_next    (pc_next),
    .target     (target),
    .link       (link),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .index      (index),
    .instr      (instr),
    .err_align  (err_align),
    .err_region (err_region),
    .clr_cnt    (clr_cnt),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        lnk;
    logic [25:0] idx;
    logic [31:0] ins;
    logic        al;
    logic        rg;
    int          cnt;
  } vec_t;

  localparam int NVEC = 6;
  vec_t tv [NVEC];
  vec_t q [$];

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request and push its expectation on the edge it is accepted.
  task automatic send(input vec_t v);
    logic hs;
    hs       = 1'b0;
    in_valid = 1'b1;
    pc_next  = v.pc;
    target   = v.tgt;
    link     = v.lnk;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      if (hs) begin
        q.push_back(v);
        break;
      end
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected acceptance within 30 cycles");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  // Output scoreboard and independent counter model, sampled mid-cycle.
  always @(negedge clk) begin
    vec_t e;
    logic hs_err;
    hs_err = 1'b0;
    chk("err_count", 32'(err_count), 32'(cnt_model));
    if (!rst) begin
      q.delete();
      cnt_model = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got instr=%0h expected no output", instr);
        end else begin
          e = q.pop_front();
          chk("index", 32'(index), 32'(e.idx));
          chk("instr", instr, e.ins);
          chk("err_align", 32'(err_align), 32'(e.al));
          chk("err_region", 32'(err_region), 32'(e.rg));
          hs_err = e.al | e.rg;
          if (!e.al && !e.rg) chk("round_trip", {e.pc[31:28], index, 2'b00}, e.tgt);
        end
      end
      if (clr_cnt) cnt_model = '0;
      else if (hs_err && cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + CNT_W'(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          pc            target        lnk  index         instr         al    rg    cnt
    tv[0] = '{32'h0040_0004, 32'h0040_0020, 1'b0, 26'h010_0008, 32'h0810_0008, 1'b0, 1'b0, 0};
    tv[1] = '{32'h0040_0004, 32'h0040_0020, 1'b1, 26'h010_0008, 32'h0C10_0008, 1'b0, 1'b0, 0};
    tv[2] = '{32'h0040_0004, 32'h0040_0022, 1'b0, 26'h010_0008, 32'h0810_0008, 1'b1, 1'b0, 1};
    tv[3] = '{32'h1000_0000, 32'h2000_0000, 1'b0, 26'h000_0000, 32'h0800_0000, 1'b0, 1'b1, 2};
    tv[4] = '{32'h0000_0004, 32'h0FFF_FFFC, 1'b0, 26'h3FF_FFFF, 32'h0BFF_FFFF, 1'b0, 1'b0, 2};
    tv[5] = '{32'h0000_0000, 32'hF000_0003, 1'b1, 26'h000_0000, 32'h0C00_0000, 1'b1, 1'b1, 3};

    rst = 1'b0; in_valid = 1'b0; pc_next = '0; target = '0; link = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_index", 32'(index), 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_flags", 32'({err_align, err_region}), 32'd0);

    // Single transactions through an empty pipe: latency and literal results.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      send(tv[i]);
      @(negedge clk);
      chk("latency_not_yet", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), 32'd1);
      drain();
      @(negedge clk);
      chk("count_after_vec", 32'(err_count), 32'(tv[i].cnt));
    end

    // Backpressure: three back-to-back inputs with the sink stalled.
    @(posedge clk); #1 out_ready = 1'b0;
    fork
      begin
        send(tv[0]);
        send(tv[1]);
        send(tv[3]);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head_instr", instr, tv[0].ins);
        @(negedge clk);
        chk("bp_stable_instr", instr, tv[0].ins);
        chk("bp_stable_index", 32'(index), 32'(tv[0].idx));
        chk("bp_still_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full discards in-flight data.
    @(posedge clk); #1 out_ready = 1'b0;
    send(tv[2]);
    send(tv[3]);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_full_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full_in_ready", 32'(in_ready), 32'd1);
    chk("rst_full_count", 32'(err_count), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_ghost", 32'(out_valid), 32'd0);

    // Saturation: 17 erroneous handshakes on a 4-bit counter.
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) send(tv[2]);
    drain();
    @(negedge clk);
    chk("count_saturated", 32'(err_count), 32'hF);

    // Clear coinciding with an erroneous handshake wins.
    @(posedge clk); #1 out_ready = 1'b0;
    send(tv[2]);
    repeat (2) @(negedge clk);
    chk("clr_pending_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 clr_cnt = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_wins", 32'(err_count), 32'd0);
    chk("clr_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_field_encoder.md
Name: jump_field_encoder

Overview:
- Inverse of the jump-target builder: converts an absolute 32-bit jump target back into the 26-bit MIPS J-type instr_index, and forms the complete J/JAL instruction word.
- Sits in the instruction-generation and self-check path of the MIPS datapath, for example in a program loader or an assembler-side test harness.
- Checks that the target is word-aligned and inside the 256 MB region of PC+4.
- Two-stage pipeline with valid/ready handshakes on both sides, plus a saturating error counter.

Parameters:
- CNT_W, 16, width of the error counter err_count.
- OP_J, 6'b000010, opcode placed in instr when link=0.
- OP_JAL, 6'b000011, opcode placed in instr when link=1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept an input this cycle.
- pc_next  in  32  PC+4 of the jump instruction.
- target  in  32  absolute jump target address.
- link  in  1  0 selects J, 1 selects JAL.
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts the output.
- index  out  26  target[27:2].
- instr  out  32  {opcode, index}.
- err_align  out  1  target[1:0] != 0.
- err_region  out  1  target[31:28] != pc_next[31:28].
- clr_cnt  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating count of erroneous output handshakes.

Behaviour:
- Reset: on posedge with rst==0:
  - both stage valid bits, out_valid and err_count go to 0;
  - index, instr and both error flags go to 0;
  - in_ready reads 1 in the following cycle.
  - Reset overrides every other event, including in-flight data, which is discarded.
- Stage 1 (S1):
  - Registers pc_next, target and link on an input handshake (in_valid && in_ready).
  - Computes err_align, err_region and index combinationally from its registered copies.
- Stage 2 (S2):
  - Registers index, the error flags and instr = {link ? OP_JAL : OP_J, index}.
  - Drives all outputs directly from S2 registers (no combinational path from inputs to outputs).
- Flow control:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load.
  - in_ready must not depend on in_valid.
- Latency and throughput:
  - An input accepted at edge k is presented with out_valid=1 after edge k+1.
  - Sustained throughput is 1 transaction per cycle while out_ready=1.
- Backpressure:
  - With out_ready held at 0, S2 holds its data and S1 holds its data.
  - in_ready falls to 0 once both stages are full.
  - Outputs stay stable while out_valid && !out_ready.
  - No transaction is dropped or reordered.
- Errors:
  - A transaction with an error still flows through; instr and index are formed regardless.
  - The flags travel with their transaction.
- err_count:
  - Increments by 1 on each output handshake whose err_align || err_region is 1.
  - Saturates at all-ones.
  - If clr_cnt and an increment occur in the same cycle, clr_cnt wins and the result is 0.
- Round-trip invariant: for an error-free transaction, {pc_next[31:28], index, 2'b00} == target.

Decomposition:
- Package mips_pkg:
  - OP_J and OP_JAL defaults;
  - typedef jfe_req_t {pc_next, target, link};
  - typedef jfe_rsp_t {instr, index, err_align, err_region}.
- One natural sub-module, jfe_stage: a generic valid/ready pipeline register parameterised on payload type. It is instantiated twice.
- The error counter stays inline.

Test Plan:
- J encode:
  - Stimulus: pc_next=32'h0040_0004, target=32'h0040_0020, link=0, out_ready=1.
  - Response two cycles later: index=26'h010_0008, instr=32'h0810_0008, both error flags 0, err_count stays 0.
- JAL encode:
  - Stimulus: same addresses with link=1.
  - Response: instr=32'h0C10_0008.
- Misaligned target:
  - Stimulus: target=32'h0040_0022.
  - Response: err_align=1, err_region=0, index=26'h010_0008, err_count becomes 1 after the handshake.
- Region error:
  - Stimulus: pc_next=32'h1000_0000, target=32'h2000_0000.
  - Response: err_region=1, index=0, instr=32'h0800_0000.
- Backpressure:
  - Stimulus: out_ready=0 while 3 back-to-back inputs are driven.
  - Response: in_ready=0 after 2 are accepted; outputs stable; on out_ready=1, 3 outputs emerge in order with no loss.
- Reset, saturation and clear:
  - rst=0 with both stages full: next cycle out_valid=0, in_ready=1, err_count=0.
  - With CNT_W=4, 17 erroneous handshakes give err_count=4'hF.
  - clr_cnt asserted together with an erroneous handshake gives err_count=0.
